// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding memorystage1.
//
// Owns the program counter and issues one instruction read per free bus cycle.
// Memory is synchronous: read data comes back the cycle after the address.
// The stage gives up the bus whenever memorystage1 claims it, and it takes
// redirects from later stages. A redirect squashes the fetch already in
// flight, so downstream only ever sees valid instructions or NOPs.
//
// Optional feature: define FETCH_STATS_EN to add the fetch_count and
// bubble_count statistics outputs.
//
// Ports:
//   clock                 in   system clock; all state changes on the rising edge
//   reset                 in   synchronous, active-high
//   memory_access_cycle   in   1 = memorystage1 owns the bus this cycle
//   jump_valid            in   single-cycle redirect request
//   jump_target           in   word address to fetch after a redirect
//   bus_data_in           in   read data for the address presented last cycle
//   bus_request           out  1 = a fetch read is on the bus this cycle
//   fetch_address         out  word address being fetched (= pc)
//   outbound_instruction  out  instruction or NOP sent to memorystage1
//   pc_out                out  address of the instruction on outbound_instruction
//   fetch_count           out  (FETCH_STATS_EN) number of instructions forwarded
//   bubble_count          out  (FETCH_STATS_EN) number of NOPs forwarded
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [4:0]  OPCODE_NOP      = 5'h1F,
    parameter logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0}
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_access_cycle,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic [31:0] bus_data_in,
    output logic        bus_request,
    output logic [31:0] fetch_address,
    output logic [31:0] outbound_instruction,
    output logic [31:0] pc_out
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    logic [31:0] pc;
    logic        fetch_pending;
    logic [31:0] pending_pc;
    logic        forward;

    // A redirect or memorystage1 bus ownership suppresses the request.
    assign bus_request   = !reset && !memory_access_cycle && !jump_valid;
    assign fetch_address = pc;

    // Data returning this cycle belongs to the previous request, unless a
    // redirect arrives now and squashes it.
    assign forward = fetch_pending && !jump_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc                   <= RESET_PC;
            fetch_pending        <= 1'b0;
            pending_pc           <= 32'h0;
            outbound_instruction <= NOP_INSTRUCTION;
            pc_out               <= 32'h0;
        end else begin
            if (jump_valid) begin
                pc            <= jump_target;
                fetch_pending <= 1'b0;
            end else if (bus_request) begin
                pc            <= pc + 32'd1;  // wraps naturally at 2^32
                fetch_pending <= 1'b1;
                pending_pc    <= pc;
            end else begin
                fetch_pending <= 1'b0;
            end

            if (forward) begin
                outbound_instruction <= bus_data_in;
                pc_out               <= pending_pc;
            end else begin
                outbound_instruction <= NOP_INSTRUCTION;
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Counted by what was forwarded, not by the data value, so a fetched
    // word that happens to equal the NOP encoding still counts as a fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count  <= 32'h0;
            bubble_count <= 32'h0;
        end else if (forward) begin
            fetch_count  <= fetch_count + 32'd1;
        end else begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stimulus, checked against a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0010;
    localparam logic [31:0] NOP    = {5'h1F, 27'h0};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        memory_access_cycle = 1'b0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] bus_data_in = 32'h0;
    logic        bus_request;
    logic [31:0] fetch_address;
    logic [31:0] outbound_instruction;
    logic [31:0] pc_out;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    fetch_stage #(
        .RESET_PC(RST_PC)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .memory_access_cycle  (memory_access_cycle),
        .jump_valid           (jump_valid),
        .jump_target          (jump_target),
        .bus_data_in          (bus_data_in),
        .bus_request          (bus_request),
        .fetch_address        (fetch_address),
        .outbound_instruction (outbound_instruction),
        .pc_out               (pc_out)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count          (fetch_count),
        .bubble_count         (bubble_count)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous memory: word at address A holds A + 0x1000. Cycles without
    // a request return garbage, so forwarding stale data gets caught.
    always @(posedge clock) begin
        if (bus_request) bus_data_in <= fetch_address + 32'h1000;
        else             bus_data_in <= $urandom;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a program counter plus a queue of addresses whose
    // read data is still on its way back from memory.
    bit          m_valid = 0;
    logic [31:0] m_pc;
    logic [31:0] m_out;
    logic [31:0] m_pc_out;
    logic [31:0] inflight[$];
    logic [31:0] m_fetches;
    logic [31:0] m_bubbles;

    task automatic model_edge(input logic r, input logic m, input logic j, input logic [31:0] t);
        bit          got_word;
        logic [31:0] addr;
        if (r) begin
            inflight.delete();
            m_pc      = RST_PC;
            m_out     = NOP;
            m_pc_out  = 32'h0;
            m_fetches = 0;
            m_bubbles = 0;
            m_valid   = 1;
            return;
        end
        // Data for the request issued in the previous cycle arrives now.
        got_word = (inflight.size() != 0);
        addr     = got_word ? inflight.pop_front() : 32'h0;
        if (j) begin
            got_word = 0;  // squashed by the redirect
            m_pc     = t;
        end else if (!m) begin
            inflight.push_back(m_pc);
            m_pc = m_pc + 1;
        end
        if (got_word) begin
            m_out    = addr + 32'h1000;
            m_pc_out = addr;
            m_fetches++;
        end else begin
            m_out = NOP;
            m_bubbles++;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational request, then check registered state after the edge.
    task automatic step(input logic r, input logic m, input logic j, input logic [31:0] t);
        @(negedge clock);
        reset = r;
        memory_access_cycle = m;
        jump_valid = j;
        jump_target = t;
        #1;
        check_eq("bus_request", {31'h0, bus_request}, {31'h0, !r && !m && !j});
        if (m_valid) check_eq("fetch_address_pre", fetch_address, m_pc);
        @(posedge clock);
        model_edge(r, m, j, t);
        #1;
        check_eq("fetch_address", fetch_address, m_pc);
        check_eq("outbound_instruction", outbound_instruction, m_out);
        check_eq("pc_out", pc_out, m_pc_out);
`ifdef FETCH_STATS_EN
        check_eq("fetch_count", fetch_count, m_fetches);
        check_eq("bubble_count", bubble_count, m_bubbles);
`endif
    endtask

    initial begin
        // Reset and straight-line fetch from RESET_PC.
        step(1, 0, 0, 32'h0);
        check_eq("reset_pc", fetch_address, 32'h10);
        check_eq("reset_out", outbound_instruction, NOP);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0);
        check_eq("pc_before_stall", fetch_address, 32'h14);
        // One stall cycle at pc=0x14.
        step(0, 1, 0, 32'h0);
        check_eq("pc_held", fetch_address, 32'h14);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        // Fetch of 0x15 is in flight; redirect to 0x80.
        step(0, 0, 1, 32'h80);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0);
        // Redirect and stall in the same cycle.
        step(0, 1, 1, 32'h40);
        check_eq("jump_with_stall_pc", fetch_address, 32'h40);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
        // Back-to-back redirects, then refetch of the current pc.
        step(0, 0, 1, 32'h200);
        step(0, 0, 1, 32'h300);
        step(0, 0, 1, 32'h300);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
        // Wrap of the program counter.
        step(0, 0, 1, 32'hFFFF_FFFE);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        check_eq("pc_wrapped", fetch_address, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
        // Run with fetches and bubbles, then reset mid-stream.
        for (int i = 0; i < 12; i++) step(0, (i % 5) == 2, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        check_eq("midreset_pc", fetch_address, RST_PC);
        check_eq("midreset_out", outbound_instruction, NOP);
`ifdef FETCH_STATS_EN
        check_eq("midreset_fetch_count", fetch_count, 32'h0);
        check_eq("midreset_bubble_count", bubble_count, 32'h0);
`endif
        step(0, 0, 0, 32'h0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r, m, j;
            logic [31:0] t;
            r = ($urandom_range(0, 199) == 0);
            m = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFFF - $urandom_range(0, 3);
                1:       t = m_pc;
                default: t = $urandom;
            endcase
            step(r, m, j, t);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
